// File: rtl/io_dma_pkg.sv
// rtl/io_dma_pkg.sv - shared state encoding and default constants for the IO DMA arbiter
package io_dma_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_STREAM = 2'd2,
      ST_DONE   = 2'd3
   } dma_state_e;

   localparam int          DEF_ADDR_W    = 18;
   localparam int          DEF_DATA_W    = 8;
   localparam int          DEF_NUM_MMIO  = 2;
   localparam logic [17:0] DEF_MMIO_BASE = 18'h3D08D;
   localparam logic [17:0] DEF_OUT_BASE  = 18'h00000;
   localparam int          DEF_OUT_LEN   = 76800;
   localparam bit          DEF_LOOP      = 1'b0;

endpackage

// File: rtl/io_skid_fifo.sv
// rtl/io_skid_fifo.sv - two-entry FIFO with synchronous flush
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   flush                 empties the FIFO on the next edge (wins over push/pop)
//   in_valid, in_data     write side; the caller guarantees space is available
//   out_valid, out_data   head of the FIFO
//   out_ready             pops the head when out_valid is high
//   count                 number of stored entries (0..2)
module io_skid_fifo #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic [1:0]        count
);

   logic [DATA_W-1:0] slot [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic              push;
   logic              pop;

   assign out_valid = (count != 2'd0);
   assign out_data  = slot[rd_ptr];
   assign pop       = out_valid && out_ready;
   // A full FIFO can still accept a write in the cycle its head leaves.
   assign push      = in_valid && ((count != 2'd2) || pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) slot[wr_ptr] <= in_data;
   end

endmodule

// File: rtl/io_dma_arbiter.sv
// rtl/io_dma_arbiter.sv - CPU/stream memory arbiter with MMIO inputs and frame streaming
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   start, abort                    run control (abort has priority)
//   cpu_done                        CPU completion flag, moves RUN to STREAM
//   cpu_addr/we/wdata, cpu_rdata    CPU data port; MMIO registers overlay memory
//   cpu_rst                         holds the CPU in reset outside RUN
//   mmio_in                         external input registers, register k in slice k
//   mem_addr/we/wdata, mem_rdata    memory port, read data one clock after address
//   out_valid/data/last, out_ready  streamed frame bytes
//   busy, done, state               status
module io_dma_arbiter
   import io_dma_pkg::*;
#(
   parameter int                ADDR_W    = DEF_ADDR_W,
   parameter int                DATA_W    = DEF_DATA_W,
   parameter int                NUM_MMIO  = DEF_NUM_MMIO,
   parameter logic [ADDR_W-1:0] MMIO_BASE = ADDR_W'(DEF_MMIO_BASE),
   parameter logic [ADDR_W-1:0] OUT_BASE  = ADDR_W'(DEF_OUT_BASE),
   parameter int                OUT_LEN   = DEF_OUT_LEN,
   parameter bit                LOOP      = DEF_LOOP
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       abort,
   input  logic                       cpu_done,
   input  logic [ADDR_W-1:0]          cpu_addr,
   input  logic                       cpu_we,
   input  logic [DATA_W-1:0]          cpu_wdata,
   output logic [DATA_W-1:0]          cpu_rdata,
   output logic                       cpu_rst,
   input  logic [NUM_MMIO*DATA_W-1:0] mmio_in,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic                       mem_we,
   output logic [DATA_W-1:0]          mem_wdata,
   input  logic [DATA_W-1:0]          mem_rdata,
   output logic                       out_valid,
   output logic [DATA_W-1:0]          out_data,
   output logic                       out_last,
   input  logic                       out_ready,
   output logic                       busy,
   output logic                       done,
   output logic [1:0]                 state
);

   // One extra bit so a full 2**ADDR_W frame length is representable.
   localparam int CNT_W = ADDR_W + 1;

   dma_state_e        cur_state;
   dma_state_e        next_state;
   logic [CNT_W-1:0]  rd_idx;
   logic              rd_pending;
   logic              rd_pending_last;
   logic              rd_last;
   logic              rd_more;
   logic              issue;
   logic              flush;
   logic              pop;
   logic [1:0]        fifo_cnt;
   logic [1:0]        free_cnt;
   logic [DATA_W:0]   fifo_head;
   logic [ADDR_W-1:0] mmio_off;
   logic              mmio_hit;
   logic [DATA_W-1:0] mmio_sel;
   logic [ADDR_W-1:0] stream_addr;

   assign mmio_off = cpu_addr - MMIO_BASE;
   assign mmio_hit = (mmio_off < ADDR_W'(NUM_MMIO));

   always_comb begin
      mmio_sel = '0;
      for (int k = 0; k < NUM_MMIO; k++) begin
         if (mmio_off == ADDR_W'(k)) mmio_sel = mmio_in[k*DATA_W +: DATA_W];
      end
   end

   assign out_valid   = (fifo_cnt != 2'd0);
   assign out_data    = fifo_head[DATA_W-1:0];
   assign out_last    = out_valid && fifo_head[DATA_W];
   assign pop         = out_valid && out_ready;
   assign stream_addr = OUT_BASE + rd_idx[ADDR_W-1:0];
   assign rd_last     = (rd_idx == CNT_W'(OUT_LEN - 1));
   assign rd_more     = LOOP || (rd_idx < CNT_W'(OUT_LEN));

   // Space that will exist after this cycle's pop, less the read already in flight.
   assign free_cnt = 2'd2 - fifo_cnt + {1'b0, pop};
   assign issue    = (cur_state == ST_STREAM) && rd_more && (free_cnt > {1'b0, rd_pending});
   assign flush    = (next_state == ST_IDLE) || (next_state == ST_RUN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cur_state <= ST_IDLE;
      else     cur_state <= next_state;
   end

   always_comb begin
      next_state = cur_state;
      cpu_rst    = 1'b1;
      mem_we     = 1'b0;
      mem_addr   = cpu_addr;
      cpu_rdata  = '0;
      unique case (cur_state)
         ST_IDLE: begin
            if (start) next_state = ST_RUN;
         end
         ST_RUN: begin
            cpu_rst   = 1'b0;
            mem_we    = cpu_we && !mmio_hit;
            cpu_rdata = mmio_hit ? mmio_sel : mem_rdata;
            if (cpu_done) next_state = ST_STREAM;
         end
         ST_STREAM: begin
            mem_addr = stream_addr;
            if (!LOOP && pop && out_last) next_state = ST_DONE;
         end
         ST_DONE: begin
            if (start) next_state = ST_RUN;
         end
         default: next_state = ST_IDLE;
      endcase
      if (abort) next_state = ST_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_idx          <= '0;
         rd_pending      <= 1'b0;
         rd_pending_last <= 1'b0;
      end else if (flush) begin
         rd_idx          <= '0;
         rd_pending      <= 1'b0;
         rd_pending_last <= 1'b0;
      end else begin
         rd_pending      <= issue;
         rd_pending_last <= issue && rd_last;
         if (issue) rd_idx <= (LOOP && rd_last) ? '0 : rd_idx + 1'b1;
      end
   end

   io_skid_fifo #(
      .DATA_W (DATA_W + 1)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (rd_pending),
      .in_data   ({rd_pending_last, mem_rdata}),
      .out_valid (),
      .out_data  (fifo_head),
      .out_ready (out_ready),
      .count     (fifo_cnt)
   );

   assign mem_wdata = cpu_wdata;
   assign busy      = (cur_state == ST_RUN) || (cur_state == ST_STREAM);
   assign done      = (cur_state == ST_DONE);
   assign state     = cur_state;

endmodule
